// File: rtl/oit_request_encoder.sv
// Request encoder: latches one-cycle request strobes into sticky pending bits and
// serves them one at a time as binary indices on a registered valid/ready port.
module oit_request_encoder #(
    parameter int COUNT       = 8,
    parameter bit ROUND_ROBIN = 1'b1,
    localparam int IW         = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [COUNT-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IW-1:0]    out_index,
    output logic [COUNT-1:0] pending,
    output logic             overflow
);

    logic [COUNT-1:0] cand;
    logic [COUNT-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    ptr;
    logic             load;
    logic             found;
    int               j;

    assign cand = pending | req;
    assign load = !out_valid || out_ready;

    // Scan all COUNT positions starting just above ptr (round-robin) or at 0 (fixed);
    // the first set candidate wins, so the pick is one-hot and always below COUNT.
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        if (load) begin
            for (int k = 0; k < COUNT; k++) begin
                if (ROUND_ROBIN) j = int'(ptr) + 1 + k;
                else             j = k;
                if (j >= COUNT) j = j - COUNT;
                if (!found && cand[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IW'(j);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            overflow  <= 1'b0;
            ptr       <= IW'(COUNT - 1);
        end else begin
            // A fresh strobe landing on a bit being granted from pending re-arms it.
            pending  <= (cand & ~grant) | (req & pending & grant);
            overflow <= |(req & pending & ~grant);
            if (load) begin
                if (found) begin
                    out_valid <= 1'b1;
                    out_index <= grant_idx;
                    ptr       <= grant_idx;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_oit_request_encoder.sv
// Bench for oit_request_encoder: three instances (fixed priority x8, round-robin x8,
// round-robin x5) share stimulus; directed steps plus random traffic against a model.
module tb_oit_request_encoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       out_ready;

    always #5 clock = ~clock;

    logic       fp_valid, rr_valid, r5_valid;
    logic [2:0] fp_index, rr_index, r5_index;
    logic [7:0] fp_pending, rr_pending;
    logic [4:0] r5_pending;
    logic       fp_ovf, rr_ovf, r5_ovf;

    oit_request_encoder #(.COUNT(8), .ROUND_ROBIN(1'b0)) u_fp (
        .clock(clock), .reset(reset), .req(req), .out_ready(out_ready),
        .out_valid(fp_valid), .out_index(fp_index), .pending(fp_pending), .overflow(fp_ovf));

    oit_request_encoder #(.COUNT(8), .ROUND_ROBIN(1'b1)) u_rr (
        .clock(clock), .reset(reset), .req(req), .out_ready(out_ready),
        .out_valid(rr_valid), .out_index(rr_index), .pending(rr_pending), .overflow(rr_ovf));

    oit_request_encoder #(.COUNT(5), .ROUND_ROBIN(1'b1)) u_r5 (
        .clock(clock), .reset(reset), .req(req[4:0]), .out_ready(out_ready),
        .out_valid(r5_valid), .out_index(r5_index), .pending(r5_pending), .overflow(r5_ovf));

    typedef struct {
        logic [7:0] pend;
        logic       valid;
        int         idx;
        int         ptr;
        logic       ovf;
    } mstate_t;

    mstate_t m_fp, m_rr, m_r5;
    int      n_vec = 0;
    int      n_mis = 0;

    // Reference: pick the first pending-or-requested line in service order
    // (ascending, or ascending modulo n from one past the last served line).
    function automatic mstate_t model_next(input mstate_t s, input int n, input bit rr,
                                           input logic rst, input logic [7:0] r,
                                           input logic rdy);
        mstate_t    t;
        logic [7:0] cand;
        int         pick;
        bit         free;
        if (rst) begin
            t.pend = '0; t.valid = 1'b0; t.idx = 0; t.ptr = n - 1; t.ovf = 1'b0;
            return t;
        end
        t    = s;
        cand = (s.pend | r) & 8'((1 << n) - 1);
        free = !s.valid || rdy;
        pick = -1;
        if (free) begin
            for (int off = 0; off < n && pick < 0; off++) begin
                int i;
                i = rr ? (s.ptr + 1 + off) % n : off;
                if (cand[i]) pick = i;
            end
        end
        t.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == pick) begin
                t.pend[i] = r[i] & s.pend[i];
            end else begin
                t.pend[i] = cand[i];
                if (r[i] && s.pend[i]) t.ovf = 1'b1;
            end
        end
        if (free) begin
            if (pick >= 0) begin
                t.valid = 1'b1; t.idx = pick; t.ptr = pick;
            end else begin
                t.valid = 1'b0;
            end
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag, input mstate_t m, input logic v,
                           input logic [2:0] idx, input logic [7:0] pend, input logic ovf);
        check({tag, ".valid"}, 32'(v), 32'(m.valid));
        check({tag, ".index"}, 32'(idx), m.idx);
        check({tag, ".pending"}, 32'(pend), 32'(m.pend));
        check({tag, ".overflow"}, 32'(ovf), 32'(m.ovf));
    endtask

    // One clock: drive, advance models with the same inputs, sample 1 time unit later.
    task automatic step(input logic rst, input logic [7:0] q, input logic rdy);
        reset = rst; req = q; out_ready = rdy;
        @(posedge clock);
        m_fp = model_next(m_fp, 8, 1'b0, rst, q, rdy);
        m_rr = model_next(m_rr, 8, 1'b1, rst, q, rdy);
        m_r5 = model_next(m_r5, 5, 1'b1, rst, q, rdy);
        #1;
        compare("fp", m_fp, fp_valid, fp_index, fp_pending, fp_ovf);
        compare("rr", m_rr, rr_valid, rr_index, rr_pending, rr_ovf);
        compare("r5", m_r5, r5_valid, r5_index, {3'b000, r5_pending}, r5_ovf);
        check("r5.index_range", 32'(r5_index < 3'd5), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req = 8'hFF; out_ready = 1'b1;

        // Reset held with all requests high.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hFF, 1'b1);
            check("rst.valid", 32'(rr_valid), 32'd0);
            check("rst.pending", 32'(rr_pending), 32'd0);
            check("rst.overflow", 32'(rr_ovf), 32'd0);
        end
        step(1'b0, 8'h00, 1'b1);
        check("idle.valid", 32'(fp_valid), 32'd0);

        // Fixed priority drain of 8'hA4.
        step(1'b0, 8'hA4, 1'b1);
        check("fp.a4.i0", 32'(fp_index), 32'd2);
        check("fp.a4.p0", 32'(fp_pending), 32'hA0);
        step(1'b0, 8'h00, 1'b1);
        check("fp.a4.i1", 32'(fp_index), 32'd5);
        check("fp.a4.p1", 32'(fp_pending), 32'h80);
        step(1'b0, 8'h00, 1'b1);
        check("fp.a4.i2", 32'(fp_index), 32'd7);
        check("fp.a4.v2", 32'(fp_valid), 32'd1);
        check("fp.a4.p2", 32'(fp_pending), 32'h00);
        step(1'b0, 8'h00, 1'b1);
        check("fp.a4.v3", 32'(fp_valid), 32'd0);

        // Backpressure: index 0 held five cycles, index 3 queued behind it.
        step(1'b0, 8'h01, 1'b0);
        check("bp.v0", 32'(fp_valid), 32'd1);
        check("bp.i0", 32'(fp_index), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h08, 1'b0);
        check("bp.pend", 32'(fp_pending), 32'h08);
        check("bp.hold_i", 32'(fp_index), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("bp.hold_v", 32'(fp_valid), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("bp.i3", 32'(fp_index), 32'd3);
        check("bp.p3", 32'(fp_pending), 32'h00);
        step(1'b0, 8'h00, 1'b1);
        check("bp.drain", 32'(fp_valid), 32'd0);

        // Round-robin with two lines held high.
        step(1'b1, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h81, 1'b1);
            check("rr.alt.i", 32'(rr_index), (k % 2 == 0) ? 32'd0 : 32'd7);
            check("rr.alt.ovf", 32'(rr_ovf), (k >= 2) ? 32'd1 : 32'd0);
        end

        // Mid-operation reset.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h01, 1'b0);
        step(1'b0, 8'h3C, 1'b0);
        check("mid.pend", 32'(rr_pending), 32'h3C);
        check("mid.valid", 32'(rr_valid), 32'd1);
        step(1'b1, 8'h00, 1'b0);
        check("mid.rst_v", 32'(rr_valid), 32'd0);
        check("mid.rst_p", 32'(rr_pending), 32'd0);
        step(1'b0, 8'h10, 1'b1);
        check("mid.fp_i", 32'(fp_index), 32'd4);
        check("mid.rr_i", 32'(rr_index), 32'd4);
        check("mid.rr_v", 32'(rr_valid), 32'd1);

        // Non-power-of-2 wrap on the five-line instance.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h11, 1'b1);
        check("r5.i0", 32'(r5_index), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("r5.i4", 32'(r5_index), 32'd4);
        step(1'b0, 8'h03, 1'b1);
        check("r5.wrap0", 32'(r5_index), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("r5.wrap1", 32'(r5_index), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("r5.idle", 32'(r5_valid), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] q;
            q = 8'($urandom) & 8'($urandom);
            step($urandom_range(0, 59) == 0, q, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
